// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter for one shared resource.
// Grants are one-hot and registered, each grant has a hold limit, and a forced
// one-cycle gap separates consecutive grants so shared nets can settle before
// the next owner drives them.
module rr_resource_arbiter #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 15,
    localparam int IW       = (N > 1) ? $clog2(N) : 1,
    localparam int HW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          C,
    input  logic          R,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy,
    output logic          timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [N-1:0]    gnt_r;
    logic [N-1:0]    gnt_s;
    logic [IW-1:0]   gnt_id_r;
    logic [IW-1:0]   gnt_id_s;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   ptr_s;
    logic [HW-1:0]   hold_cnt_r;
    logic [HW-1:0]   hold_cnt_s;
    logic            busy_r;
    logic            timeout_r;
    logic            timeout_s;
    logic            found_s;
    logic [IW-1:0]   sel_s;

    // Index 'base + off' reduced modulo N (off is always < N).
    function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base, input int off);
        int t;
        t = int'(base) + off;
        if (t >= N) begin
            t = t - N;
        end else begin
            t = t;
        end
        return IW'(t);
    endfunction

    // One-hot vector with only bit 'idx' set.
    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v = {N{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Pick the first active requester at or after the priority pointer.
    always_comb begin
        found_s = 1'b0;
        sel_s   = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (!found_s && req[rot_idx(ptr_r, i)]) begin
                found_s = 1'b1;
                sel_s   = rot_idx(ptr_r, i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic for the grant/gap/hold-limit sequencer.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        gnt_id_s   = gnt_id_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_GAP: begin
                if (found_s) begin
                    gnt_s      = onehot(sel_s);
                    gnt_id_s   = sel_s;
                    hold_cnt_s = HW'(1);
                    state_s    = ST_GRANT;
                end else begin
                    gnt_s   = {N{1'b0}};
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A dropped request wins over the hold limit: that is a normal release.
                if (!req[gnt_id_r]) begin
                    gnt_s   = {N{1'b0}};
                    ptr_s   = rot_idx(gnt_id_r, 1);
                    state_s = ST_GAP;
                end else if (hold_cnt_r == HW'(MAX_HOLD)) begin
                    gnt_s     = {N{1'b0}};
                    ptr_s     = rot_idx(gnt_id_r, 1);
                    state_s   = ST_GAP;
                    timeout_s = 1'b1;
                end else begin
                    hold_cnt_s = hold_cnt_r + HW'(1);
                end
            end
            default: begin
                gnt_s   = {N{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_r    <= ST_IDLE;
            gnt_r      <= {N{1'b0}};
            gnt_id_r   <= {IW{1'b0}};
            ptr_r      <= {IW{1'b0}};
            hold_cnt_r <= {HW{1'b0}};
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            gnt_id_r   <= gnt_id_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
            busy_r     <= |gnt_s;
            timeout_r  <= timeout_s;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_id  = gnt_id_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed self-checking bench for rr_resource_arbiter (N=4, MAX_HOLD=4).
module tb_rr_resource_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic         C;
    logic         R;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;

    int n_tests = 0;
    int n_fail  = 0;

    rr_resource_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .C       (C),
        .R       (R),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    // Free-running clock.
    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] eg, input logic eto);
        check_eq({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check_eq({tag, ".timeout"}, 32'(timeout), 32'(eto));
    endtask

    // Structural invariants, sampled away from the active edge.
    always @(negedge C) begin
        check_eq("onehot0", 32'($onehot0(gnt)), 32'd1);
        check_eq("busy_eq_or_gnt", 32'(busy), 32'(|gnt));
    end

    initial begin
        R   = 1'b0;
        req = 4'b0000;
        tick();
        tick();
        check_eq("rst.gnt", 32'(gnt), 32'd0);
        check_eq("rst.gnt_id", 32'(gnt_id), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.timeout", 32'(timeout), 32'd0);
        #2 R = 1'b1;

        // 1: reset mid-grant drops the grant at once
        req = 4'b0001;
        tick();
        expect_out("t1.grant", 4'b0001, 1'b0);
        R = 1'b0;
        #1;
        check_eq("t1.async_gnt", 32'(gnt), 32'd0);
        check_eq("t1.async_busy", 32'(busy), 32'd0);
        #1 R = 1'b1;
        req = 4'b1010;
        tick();
        expect_out("t1.after_rst", 4'b0010, 1'b0);
        check_eq("t1.gnt_id", 32'(gnt_id), 32'd1);
        req = 4'b0000;
        tick();
        tick();
        R = 1'b0;
        #2 R = 1'b1;

        // 2: round-robin order with one idle cycle between grants
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] eg;
            eg = 4'b0001 << (k % 4);
            tick();
            expect_out("t2.hold1", eg, 1'b0);
            check_eq("t2.gnt_id", 32'(gnt_id), 32'(k % 4));
            tick();
            expect_out("t2.hold2", eg, 1'b0);
            req = req & ~eg;
            tick();
            expect_out("t2.gap", 4'b0000, 1'b0);
            req = (k == 4) ? 4'b0000 : 4'b1111;
        end
        tick();
        expect_out("t2.idle", 4'b0000, 1'b0);

        // 3: constant request is force-released after MAX_HOLD cycles
        req = 4'b0100;
        for (int c = 0; c < MAX_HOLD; c++) begin
            tick();
            expect_out("t3.hold", 4'b0100, 1'b0);
        end
        tick();
        expect_out("t3.timeout", 4'b0000, 1'b1);
        check_eq("t3.busy_gap", 32'(busy), 32'd0);
        tick();
        expect_out("t3.regrant", 4'b0100, 1'b0);

        // 4: pointer wraps 3 -> 0
        req = 4'b0000;
        tick();
        expect_out("t4.release", 4'b0000, 1'b0);
        req = 4'b0011;
        tick();
        expect_out("t4.wrap", 4'b0001, 1'b0);
        check_eq("t4.gnt_id", 32'(gnt_id), 32'd0);

        // 5: a new request does not preempt the owner
        req = 4'b1001;
        tick();
        expect_out("t5.nopreempt1", 4'b0001, 1'b0);
        tick();
        expect_out("t5.nopreempt2", 4'b0001, 1'b0);
        req = 4'b1000;
        tick();
        expect_out("t5.gap", 4'b0000, 1'b0);
        tick();
        expect_out("t5.next", 4'b1000, 1'b0);
        check_eq("t5.gnt_id", 32'(gnt_id), 32'd3);
        req = 4'b0000;
        tick();
        tick();

        // 6: request drop on the hold-limit edge is a normal release
        req = 4'b0010;
        for (int c = 0; c < MAX_HOLD; c++) begin
            tick();
            expect_out("t6.hold", 4'b0010, 1'b0);
        end
        req = 4'b0000;
        tick();
        expect_out("t6.simul", 4'b0000, 1'b0);
        check_eq("t6.gnt_id_kept", 32'(gnt_id), 32'd1);
        tick();
        expect_out("t6.idle", 4'b0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
